// File: rtl/mux21_pattern_gen.sv
// mux21_pattern_gen
// Stimulus sequencer and checker for a combinational 2:1 mux (mux21b).
// Steps (a,b,s) through all 8 combinations from a 3-bit index
// (s = idx[2], a = idx[1], b = idx[0]). Each pattern is held for HOLD_CYCLES
// clocks. The returned y_in is compared against s ? b : a in the last cycle
// of every hold window, and mismatches are counted.
//
// Optional build macro: MUX21_PATGEN_LOOP_EN
//   undefined : one sweep per accepted start, RUN -> DONE -> IDLE.
//   defined   : sweeps repeat back to back while busy stays high. done pulses
//               at every wrap, and the error outputs latch the completed
//               sweep's result on that pulse. Only rst leaves the loop.

module mux21_pattern_gen #(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       s,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_cnt,
    output logic [2:0] first_err_idx,
    output logic       err_any
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value that marks the check (last) cycle of a hold window.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Running accumulators for the sweep in progress.
    logic [3:0]       r_acc_cnt;
    logic [3:0]       w_acc_cnt_nxt;
    logic [2:0]       r_acc_first;
    logic [2:0]       w_acc_first_nxt;

    // Accumulator values after folding in the current cycle's check result.
    logic [3:0]       w_fin_cnt;
    logic [2:0]       w_fin_first;

    logic             r_a;
    logic             r_b;
    logic             r_s;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_check;
    logic             w_expect;
    logic             w_mismatch;

    // The expected value comes from the index rather than from the a/b/s
    // registers. A fault on the driven pins then appears as a mismatch and
    // is not silently mirrored.
    assign w_expect   = r_idx[2] ? r_idx[0] : r_idx[1];
    assign w_check    = (r_state == ST_RUN) && (r_cnt == LAST_CNT);
    assign w_mismatch = w_check && (y_in != w_expect);

    assign w_fin_cnt   = r_acc_cnt + {3'b000, w_mismatch};
    assign w_fin_first = (w_mismatch && (r_acc_cnt == 4'd0)) ? r_idx : r_acc_first;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next index/counter and accumulator updates
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_acc_cnt_nxt   = r_acc_cnt;
        w_acc_first_nxt = r_acc_first;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = ST_RUN;
                    w_idx_nxt       = 3'd0;
                    w_cnt_nxt       = '0;
                    w_acc_cnt_nxt   = 4'd0;
                    w_acc_first_nxt = 3'd0;
                end
            end

            ST_RUN: begin
                w_cnt_nxt       = r_cnt + CNT_ONE;
                w_acc_cnt_nxt   = w_fin_cnt;
                w_acc_first_nxt = w_fin_first;
                if (w_check) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_done_nxt = 1'b1;
`ifdef MUX21_PATGEN_LOOP_EN
                        // Wrap into the next sweep with no gap. The finished
                        // result is latched into the outputs separately.
                        w_idx_nxt       = 3'd0;
                        w_acc_cnt_nxt   = 4'd0;
                        w_acc_first_nxt = 3'd0;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. a/b/s, busy and done are registered from the next
    // state, so pattern 0 appears in the first cycle after the start is
    // accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= 3'd0;
            r_cnt       <= '0;
            r_acc_cnt   <= 4'd0;
            r_acc_first <= 3'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_s         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc_cnt   <= w_acc_cnt_nxt;
            r_acc_first <= w_acc_first_nxt;
            r_a         <= (w_state_nxt == ST_RUN) ? w_idx_nxt[1] : 1'b0;
            r_b         <= (w_state_nxt == ST_RUN) ? w_idx_nxt[0] : 1'b0;
            r_s         <= (w_state_nxt == ST_RUN) ? w_idx_nxt[2] : 1'b0;
            r_busy      <= (w_state_nxt == ST_RUN);
            r_done      <= w_done_nxt;
        end
    end

`ifdef MUX21_PATGEN_LOOP_EN
    logic [3:0] r_err_cnt;
    logic [2:0] r_err_first;

    // Result latch: capture the completed sweep at each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt   <= 4'd0;
            r_err_first <= 3'd0;
        end else if (w_done_nxt) begin
            r_err_cnt   <= w_fin_cnt;
            r_err_first <= w_fin_first;
        end
    end

    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_err_first;
`else
    // The accumulators hold through DONE/IDLE until the next accepted start.
    assign err_cnt       = r_acc_cnt;
    assign first_err_idx = r_acc_first;
`endif

    assign err_any = (err_cnt != 4'd0);
    assign a       = r_a;
    assign b       = r_b;
    assign s       = r_s;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
